// File: rtl/sky130_as_sc_hs__scanbank.sv
// Scan bank: N-bit capture/shift/update chain with a one-cycle DONE pulse.
// Optional parity check on shifted data enabled by macro SC_HS_SCANBANK_PARITY_EN.
module sky130_as_sc_hs__scanbank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     VPWR,
  input  logic                     VGND,
  input  logic                     VPB,
  input  logic                     VNB,
  input  logic                     START,
  input  logic [1:0]               MODE,
  input  logic                     SI,
  output logic                     SO,
  input  logic [WIDTH*DEPTH-1:0]   PI,
  output logic [WIDTH*DEPTH-1:0]   PO,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     PERR
);

  localparam int N  = WIDTH * DEPTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHIFT   = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_chain;
  logic [N-1:0]    w_chain_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [N-1:0]    r_po;
  logic            r_busy;
  logic            r_done;
  logic            w_accept;
  logic            w_update;
  logic            w_po_en;
  logic            w_unused_supply;

  // Supply and bias pins carry no logic function.
  assign w_unused_supply = VPWR ^ VGND ^ VPB ^ VNB;

  assign w_update = (r_state == S_UPDATE);

  always_comb begin
    w_state_nxt = r_state;
    w_chain_nxt = r_chain;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START && (MODE != 2'b11)) begin
          w_accept = 1'b1;
          case (MODE)
            2'b00:   w_state_nxt = S_SHIFT;
            2'b01:   w_state_nxt = S_CAPTURE;
            2'b10:   w_state_nxt = S_UPDATE;
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        w_chain_nxt = PI;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_chain_nxt = {r_chain[N-2:0], SI};
        if (r_cnt == CW'(N - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_UPDATE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_chain <= '0;
      r_cnt   <= '0;
      r_po    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_chain <= w_chain_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_update;
      if (w_po_en) begin
        r_po <= r_chain;
      end
    end
  end

`ifdef SC_HS_SCANBANK_PARITY_EN
  logic r_par;
  logic r_perr;
  logic w_par_err;

  // SI in the UPDATE cycle is the even-parity bit for the shifted data.
  assign w_par_err = r_par ^ SI;
  assign w_po_en   = w_update && !w_par_err;
  assign PERR      = r_perr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_accept) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_par  <= r_par ^ SI;
    end else if (w_update && w_par_err) begin
      r_perr <= 1'b1;
    end
  end
`else
  assign w_po_en = w_update;
  assign PERR    = 1'b0;
`endif

  assign SO   = r_chain[N-1];
  assign PO   = r_po;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_sky130_as_sc_hs__scanbank.sv
// Self-checking bench for sky130_as_sc_hs__scanbank: vector table, corner sequences, random ops.
module tb_sky130_as_sc_hs__scanbank;

  localparam int N = 32;
`ifdef SC_HS_SCANBANK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   MODE = 2'b00;
  logic         SI = 1'b0;
  logic [N-1:0] PI = '0;
  logic         SO;
  logic [N-1:0] PO;
  logic         BUSY, DONE, PERR;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] m_chain = '0;
  logic [N-1:0] m_po = '0;

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] word;
    logic [N-1:0] pi;
    logic         par;
    logic [N-1:0] po;
    int           done;
    bit           glitch;
  } vec_t;
  vec_t tbl[6];

  sky130_as_sc_hs__scanbank #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0),
    .START(START), .MODE(MODE), .SI(SI), .SO(SO), .PI(PI), .PO(PO),
    .BUSY(BUSY), .DONE(DONE), .PERR(PERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation; DONE index counts samples, the sample after the START edge being 1.
  task automatic run_op(input logic [1:0] mode, input logic [N-1:0] word, input logic [N-1:0] pi,
                        input logic par_si, input logic [N-1:0] exp_po, input int exp_done,
                        input bit glitch);
    int done_at, done_n, busy_n, shift_lo, upd_k;
    logic [N-1:0] so_w, old_chain;
    logic e_perr;
    done_at = 0; done_n = 0; busy_n = 0; so_w = '0;
    old_chain = m_chain;
    shift_lo = (mode == 2'd1) ? 2 : 1;
    upd_k = (mode == 2'd2) ? 1 : shift_lo + N;
    e_perr = PAR_EN & (((mode == 2'd2) ? 1'b0 : ^word) ^ par_si);
    @(negedge CLK);
    START = 1'b1; MODE = mode; PI = pi; SI = 1'b0;
    for (int k = 1; k <= exp_done + 4; k++) begin
      @(negedge CLK);
      START = (glitch && (k == 5 || k == 6)) ? 1'b1 : 1'b0;
      if (k == 1) check("perr_clear_at_start", PERR, 1'b0);
      busy_n += int'(BUSY);
      if (DONE) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (mode != 2'd2 && k >= shift_lo && k < shift_lo + N) so_w = {so_w[N-2:0], SO};
      if (mode != 2'd2 && k >= shift_lo && k < shift_lo + N) SI = word[N-1-(k-shift_lo)];
      else if (k == upd_k) SI = par_si;
      else SI = 1'b0;
    end
    check("done_latency", done_at, exp_done);
    check("done_count", done_n, 1);
    check("busy_cycles", busy_n, exp_done - 1);
    check("po", PO, exp_po);
    check("perr", PERR, e_perr);
    if (mode != 2'd2) check("so_stream", so_w, (mode == 2'd1) ? pi : old_chain);
    if (mode != 2'd2) m_chain = word;
    m_po = exp_po;
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'hA5A50F0F, 32'h0,        1'b0, 32'hA5A50F0F, 34, 1'b1};
    tbl[1] = '{2'd1, 32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 35, 1'b0};
    tbl[2] = '{2'd2, 32'h0,        32'h0,        1'b0, 32'h00000000, 2,  1'b0};
    tbl[3] = '{2'd0, 32'hFFFF0000, 32'h0,        1'b0, 32'hFFFF0000, 34, 1'b0};
    tbl[4] = '{2'd2, 32'h0,        32'h0,        1'b0, 32'hFFFF0000, 2,  1'b0};
    tbl[5] = '{2'd1, 32'h000000FF, 32'hDEADBEEF, 1'b0, 32'h000000FF, 35, 1'b1};

    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_so", SO, 1'b0);
    check("rst_po", PO, 32'h0);
    check("rst_perr", PERR, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].mode, tbl[i].word, tbl[i].pi, tbl[i].par, tbl[i].po, tbl[i].done, tbl[i].glitch);

    // Reserved mode is ignored entirely.
    begin
      int act_n;
      act_n = 0;
      @(negedge CLK); START = 1'b1; MODE = 2'b11;
      for (int k = 0; k < 6; k++) begin
        @(negedge CLK); START = 1'b0;
        act_n += int'(BUSY) + int'(DONE);
      end
      check("mode11_ignored", act_n, 0);
      check("mode11_po", PO, m_po);
      check("mode11_so", SO, m_chain[N-1]);
    end

    // Parity sequence: bad parity bit, then good parity bit.
    run_op(2'd0, 32'h00000001, 32'h0, 1'b0, PAR_EN ? m_po : 32'h00000001, N + 2, 1'b0);
    run_op(2'd0, 32'h00000001, 32'h0, 1'b1, 32'h00000001, N + 2, 1'b0);

    // Reset in the tenth SHIFT cycle aborts the operation asynchronously.
    begin
      int done_n;
      done_n = 0;
      @(negedge CLK); START = 1'b1; MODE = 2'b00; SI = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge CLK); START = 1'b0;
      end
      #2 RST = 1'b1;
      #1;
      check("abort_busy", BUSY, 1'b0);
      check("abort_done", DONE, 1'b0);
      check("abort_so", SO, 1'b0);
      check("abort_po", PO, 32'h0);
      check("abort_perr", PERR, 1'b0);
      @(negedge CLK); RST = 1'b0; SI = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge CLK);
        done_n += int'(DONE) + int'(BUSY);
      end
      check("abort_no_done", done_n, 0);
      m_chain = '0; m_po = '0;
    end

    // START held across DONE: second operation starts in the DONE cycle.
    begin
      int d1, d2, dn;
      d1 = 0; d2 = 0; dn = 0;
      @(negedge CLK); START = 1'b1; MODE = 2'b00; SI = 1'b0;
      for (int k = 1; k <= 2 * N + 8; k++) begin
        @(negedge CLK);
        if (d1 != 0 && k == d1 + 1) START = 1'b0;
        if (DONE) begin
          dn++;
          if (d1 == 0) d1 = k; else if (d2 == 0) d2 = k;
        end
      end
      START = 1'b0;
      check("b2b_first_done", d1, N + 2);
      check("b2b_gap", d2 - d1, N + 2);
      check("b2b_count", dn, 2);
      m_chain = '0; m_po = '0;
    end

    // Randomized operations against the model.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] md;
      logic [N-1:0] w, p, e_po;
      logic bad, ps;
      int ed;
      md = 2'($urandom_range(0, 2));
      w = $urandom;
      p = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      ps = ((md == 2'd2) ? 1'b0 : ^w) ^ bad;
      e_po = (PAR_EN && bad) ? m_po : ((md == 2'd2) ? m_chain : w);
      ed = (md == 2'd0) ? N + 2 : (md == 2'd1) ? N + 3 : 2;
      run_op(md, w, p, ps, e_po, ed, (md != 2'd2) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
